sn74ls165_scan_ctrl: RTL and testbench
======================================

Name: sn74ls165_scan_ctrl

Overview:
- Single-clock controller that sequences a chain of N_DEV SN74LS165 parallel-in/serial-out shift registers.
- Generates the active-low parallel-load strobe and the shift clock, samples the chain's serial output Q7, and assembles a WIDTH-bit word.
- Presents the word to a consumer through a Valid/Ready handshake.
- Sits between the board-level '165 chain and the system logic that reads switch/input banks.

Parameters:
- N_DEV, 1, number of cascaded '165 devices (Q7 of device i feeds DS of device i-1).
- WIDTH, 8*N_DEV, bits per scan (derived; not overridden independently).
- CLK_DIV, 2, system clocks per shift-clock half-period and per PL phase (minimum 1).

Ports:
- Clock  in  1  system clock; all state updates on posedge.
- Reset  in  1  synchronous, active-low reset.
- Start  in  1  request one scan; sampled only in IDLE.
- Auto  in  1  1 = rescan automatically after each accepted word.
- SerIn  in  1  Q7 of the last '165 in the chain.
- PL  out  1  parallel load to the chain, active low.
- SrClk  out  1  shift clock to the chain (drives Clock1; board ties Clock2 low).
- Data  out  WIDTH  assembled word; bit WIDTH-1 is the first bit sampled.
- Valid  out  1  Data holds a complete scan.
- Ready  in  1  consumer accepts Data when Valid && Ready.
- Busy  out  1  scan in progress (state not IDLE and not DONE).

Behaviour:
- Reset (Reset==0 at a posedge) dominates all other inputs, including mid-scan. State goes to IDLE.
  - Reset values: PL=1, SrClk=0, Data=0, Valid=0, Busy=0; bit and phase counters cleared.
- States: IDLE, LOAD, HOLD, SHIFT_HI, SHIFT_LO, DONE.
- IDLE: if Start, or Auto==1 after a completed handshake, go to LOAD.
- LOAD: PL=0 for CLK_DIV cycles, then go to HOLD.
- HOLD: PL=1, SrClk=0 for CLK_DIV cycles. On the last cycle, sample SerIn into Data[WIDTH-1] (P7 of the nearest device); bit counter = 1.
- Bits remaining (counter < WIDTH): SHIFT_HI holds SrClk=1 for CLK_DIV cycles, then SHIFT_LO holds SrClk=0 for CLK_DIV cycles. On the last SHIFT_LO cycle, sample SerIn into Data[WIDTH-1-counter]; counter += 1.
- Counter == WIDTH after a sample: go to DONE. Valid=1 on the next cycle.
- Latency: Valid rises 2*CLK_DIV*WIDTH+1 posedges after the edge that accepted Start.
- Sampling happens only while SrClk=0, at least CLK_DIV cycles after the last SrClk rise, so each bit is settled.
- Data is stable while Valid=1. Data is not cleared between scans; it is overwritten bit by bit during the next scan.
- DONE: hold Valid until Valid && Ready at a posedge, then clear Valid.
  - Same edge, Auto==1: go to LOAD directly (back-to-back scans, no IDLE cycle).
  - Same edge, Auto==0: go to IDLE.
- Start while Busy or in DONE: ignored, not queued.
- Start and Auto both high in IDLE: one scan starts (no double start).
- Ready while Valid==0: ignored.
- Backpressure: no new scan starts while Valid=1, so no overrun is possible.
- PL and SrClk are registered outputs (glitch-free). PL=0 and SrClk=1 never occur in the same cycle.

Decomposition:
- Package psd_sr_pkg holds:
  - scan_state_t enum (the six states).
  - Localparam helper for counter width, $clog2(WIDTH+1).
  - Default CLK_DIV constant.
- Sub-module sr_phase_timer: counts CLK_DIV cycles per phase; restart input, last-cycle pulse output. It is the natural split, reused for LOAD, HOLD, SHIFT_HI and SHIFT_LO.

Test Plan:
- Reset mid-scan: Start, then Reset=0 at the 5th SHIFT_HI cycle → next edge PL=1, SrClk=0, Valid=0, Busy=0, Data=0; a following Start completes a normal scan.
- Single device: N_DEV=1, CLK_DIV=1, behavioural '165 model loaded with P7..P0=8'b1011_0010, Start pulse → Valid exactly 17 edges later, Data=8'hB2, exactly 7 SrClk rising edges observed.
- Chain: N_DEV=2, CLK_DIV=3, near device 8'hA5, far device 8'h3C → Data=16'hA53C. Latency 97 edges. Every PL low pulse and SrClk half-period is 3 cycles.
- Backpressure: Ready=0 for 20 cycles after Valid → Data and Valid hold, SrClk/PL idle, Start pulses ignored. Ready=1 → Valid drops next edge.
- Auto mode: Auto=1, Ready=1, device inputs changed between scans (8'h00 then 8'hFF) → consecutive words 8'h00, 8'hFF; LOAD begins on the edge after each handshake.
- Handshake corners: Ready held high before Valid (accepted on first Valid cycle, Valid high exactly 1 cycle); Start and Auto asserted together in IDLE (exactly one PL low pulse).

Source files
------------

// File: rtl/psd_sr_pkg.sv
// Shared types and constants for the SN74LS165 scan controller.
package psd_sr_pkg;

    // Controller states; see the table in sn74ls165_scan_ctrl for meanings.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        HOLD     = 3'd2,
        SHIFT_HI = 3'd3,
        SHIFT_LO = 3'd4,
        DONE     = 3'd5
    } scan_state_t;

    // System clocks per PL phase and per shift-clock half-period.
    localparam int CLK_DIV_DEFAULT = 2;

    // Each '165 contributes one byte to the scanned word.
    localparam int BITS_PER_DEV = 8;

    // Bit counter has to reach WIDTH itself, hence the +1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sn74ls165_scan_ctrl_if.sv
// Valid/Ready word interface between the scan controller and its consumer.
interface sn74ls165_scan_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] Data;
    logic             Valid;
    logic             Ready;

    modport master (
        output Data,
        output Valid,
        input  Ready
    );

    modport slave (
        input  Data,
        input  Valid,
        output Ready
    );
endinterface

// File: rtl/sn74ls165_scan_ctrl_timer.sv
// Phase timer: times out after CLK_DIV cycles from the last restart.
// Shared by the LOAD, HOLD, SHIFT_HI and SHIFT_LO phases.
module sr_phase_timer
    import psd_sr_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic Clock,
    input  logic Reset,
    input  logic restart,
    output logic last
);
    localparam int TW = $clog2(CLK_DIV + 1);

    logic [TW-1:0] cnt;

    // Down-counter loaded on restart; parks at zero, which is the terminal count.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= TW'(CLK_DIV - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - TW'(1);
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/sn74ls165_scan_ctrl.sv
// Scan controller for a chain of SN74LS165 PISO shift registers.
// Loads the chain, clocks it out bit by bit and hands the word over Valid/Ready.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | waiting for Start (or Auto after an accepted word)
//   LOAD     | PL low, chain captures its parallel inputs
//   HOLD     | PL high, SrClk low; first bit (P7 of nearest) sampled at end
//   SHIFT_HI | SrClk high, chain advances one bit
//   SHIFT_LO | SrClk low; next bit sampled at end of phase
//   DONE     | word complete, Valid held until accepted
module sn74ls165_scan_ctrl
    import psd_sr_pkg::*;
#(
    parameter int N_DEV   = 1,
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Auto,
    input  logic                  SerIn,
    output logic                  PL,
    output logic                  SrClk,
    output logic                  Busy,
    sn74ls165_scan_ctrl_if.master bus
);
    localparam int WIDTH = BITS_PER_DEV * N_DEV;
    localparam int CNT_W = cnt_width(WIDTH);
    localparam int IDX_W = $clog2(WIDTH);

    scan_state_t      state;
    scan_state_t      state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_nxt;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             hs_done;
    logic             handshake;
    logic             phase_last;
    logic             phase_restart;
    logic             sample;
    logic [IDX_W-1:0] sample_idx;

    assign handshake     = valid_q && bus.Ready;
    assign phase_restart = (state_nxt != state);

    sr_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_timer (
        .Clock   (Clock),
        .Reset   (Reset),
        .restart (phase_restart),
        .last    (phase_last)
    );

    // Next-state, bit counter and sample strobe for the scan sequence.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        sample      = 1'b0;
        sample_idx  = IDX_W'(WIDTH - 1);
        unique case (state)
            IDLE: begin
                // Start and Auto together still yield a single LOAD entry.
                if (Start || (Auto && hs_done)) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (phase_last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // Q7 already shows P7 of the nearest device after the load.
                if (phase_last) begin
                    sample      = 1'b1;
                    sample_idx  = IDX_W'(WIDTH - 1);
                    bit_cnt_nxt = CNT_W'(1);
                    state_nxt   = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (phase_last) begin
                    state_nxt = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                // Sample a full half-period after the rising edge so Q7 is settled.
                if (phase_last) begin
                    sample      = 1'b1;
                    sample_idx  = IDX_W'(WIDTH - 1) - bit_cnt[IDX_W-1:0];
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    state_nxt   = (bit_cnt_nxt == CNT_W'(WIDTH)) ? DONE : SHIFT_HI;
                end
            end
            DONE: begin
                // Back-to-back scans skip IDLE so LOAD follows the handshake edge.
                if (handshake) begin
                    state_nxt = Auto ? LOAD : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counter and registered chain strobes (PL/SrClk decoded from next state).
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            PL      <= 1'b1;
            SrClk   <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            PL      <= (state_nxt != LOAD);
            SrClk   <= (state_nxt == SHIFT_HI);
        end
    end

    // Word assembly; Data is only overwritten bit by bit during the next scan.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            data_q <= '0;
        end else if (sample) begin
            data_q[sample_idx] <= SerIn;
        end
    end

    // Valid rises one cycle into DONE and drops on the accepting edge.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            valid_q <= 1'b0;
        end else if (handshake) begin
            valid_q <= 1'b0;
        end else if (state == DONE) begin
            valid_q <= 1'b1;
        end
    end

    // Remembers an accepted word so Auto alone can restart from IDLE.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            hs_done <= 1'b0;
        end else if (handshake) begin
            hs_done <= 1'b1;
        end else if ((state == IDLE) && (state_nxt == LOAD)) begin
            hs_done <= 1'b0;
        end
    end

    assign bus.Data  = data_q;
    assign bus.Valid = valid_q;
    assign Busy      = (state != IDLE) && (state != DONE);

endmodule

// File: tb/tb_sn74ls165_scan_ctrl.sv
// Directed bench: single-device DUT (CLK_DIV=1) and two-device chain (CLK_DIV=3),
// each fed by a behavioural '165 chain.
module tb_sn74ls165_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Single device, CLK_DIV = 1
    logic rst_a = 1'b0, start_a = 1'b0, auto_a = 1'b0;
    logic ser_a, pl_a, srclk_a, busy_a;
    logic [7:0] par_a = 8'h00;
    logic [7:0] sr_a = 8'h00;
    sn74ls165_scan_ctrl_if #(.WIDTH(8)) bus_a ();

    sn74ls165_scan_ctrl #(.N_DEV(1), .CLK_DIV(1)) dut_a (
        .Clock (clk),
        .Reset (rst_a),
        .Start (start_a),
        .Auto  (auto_a),
        .SerIn (ser_a),
        .PL    (pl_a),
        .SrClk (srclk_a),
        .Busy  (busy_a),
        .bus   (bus_a.master)
    );

    // Two-device chain, CLK_DIV = 3; par_b = {near, far}
    logic rst_b = 1'b0, start_b = 1'b0, auto_b = 1'b0;
    logic ser_b, pl_b, srclk_b, busy_b;
    logic [15:0] par_b = 16'h0000;
    logic [15:0] sr_b = 16'h0000;
    sn74ls165_scan_ctrl_if #(.WIDTH(16)) bus_b ();

    sn74ls165_scan_ctrl #(.N_DEV(2), .CLK_DIV(3)) dut_b (
        .Clock (clk),
        .Reset (rst_b),
        .Start (start_b),
        .Auto  (auto_b),
        .SerIn (ser_b),
        .PL    (pl_b),
        .SrClk (srclk_b),
        .Busy  (busy_b),
        .bus   (bus_b.master)
    );

    // '165 chain model: async parallel load while PL low, shift on SrClk rise.
    always @(negedge pl_a or posedge srclk_a)
        if (!pl_a) sr_a <= par_a;
        else       sr_a <= {sr_a[6:0], 1'b0};
    assign ser_a = sr_a[7];

    always @(negedge pl_b or posedge srclk_b)
        if (!pl_b) sr_b <= par_b;
        else       sr_b <= {sr_b[14:0], 1'b0};
    assign ser_b = sr_b[15];

    int rise_a = 0, plfall_a = 0, rise_b = 0;
    always @(posedge srclk_a) rise_a = rise_a + 1;
    always @(negedge pl_a)    plfall_a = plfall_a + 1;
    always @(posedge srclk_b) rise_b = rise_b + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past one posedge and stop on the following negedge.
    task automatic tick();
        @(negedge clk);
    endtask

    int rise0, fall0;
    logic pl_log    [0:97];
    logic srclk_log [0:97];
    logic busy_log  [0:97];
    logic valid_log [0:97];
    int mm_pl, mm_sr, mm_busy;

    initial begin
        bus_a.Ready = 1'b0;
        bus_b.Ready = 1'b0;
        repeat (3) tick();

        // Reset state
        check("a_rst_ctl",  {28'd0, pl_a, srclk_a, bus_a.Valid, busy_a}, 32'b1000);
        check("a_rst_data", {24'd0, bus_a.Data}, 32'h0);
        check("b_rst_ctl",  {28'd0, pl_b, srclk_b, bus_b.Valid, busy_b}, 32'b1000);
        check("b_rst_data", {16'd0, bus_b.Data}, 32'h0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();

        // Single device scan, 8'hB2, latency 17 edges, 7 SrClk rises
        par_a = 8'hB2;
        rise0 = rise_a;
        fall0 = plfall_a;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("a_load_ctl", {29'd0, pl_a, srclk_a, busy_a}, 32'b001);
        repeat (16) tick();
        check("a_lat16_valid", {31'd0, bus_a.Valid}, 32'd0);
        tick();
        check("a_lat17_valid", {31'd0, bus_a.Valid}, 32'd1);
        check("a_data_b2", {24'd0, bus_a.Data}, 32'hB2);
        check("a_rises", rise_a - rise0, 32'd7);
        check("a_plfalls", plfall_a - fall0, 32'd1);

        // Backpressure: Ready low for 20 cycles, Start pulses ignored
        par_a = 8'h00;
        for (int i = 0; i < 20; i++) begin
            start_a = (i % 3 == 0);
            tick();
        end
        start_a = 1'b0;
        check("a_bp_valid", {31'd0, bus_a.Valid}, 32'd1);
        check("a_bp_data", {24'd0, bus_a.Data}, 32'hB2);
        check("a_bp_idle_ctl", {29'd0, pl_a, srclk_a, busy_a}, 32'b100);
        check("a_bp_rises", rise_a - rise0, 32'd7);
        check("a_bp_plfalls", plfall_a - fall0, 32'd1);
        bus_a.Ready = 1'b1;
        tick();
        check("a_bp_accept", {30'd0, bus_a.Valid, busy_a}, 32'b00);

        // Ready held high before Valid: Valid high exactly one cycle
        par_a = 8'h5A;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (16) tick();
        check("a_rdy_pre", {31'd0, bus_a.Valid}, 32'd0);
        tick();
        check("a_rdy_valid", {31'd0, bus_a.Valid}, 32'd1);
        check("a_rdy_data", {24'd0, bus_a.Data}, 32'h5A);
        tick();
        check("a_rdy_drop", {30'd0, bus_a.Valid, busy_a}, 32'b00);

        // Start and Auto together in IDLE: exactly one PL pulse
        bus_a.Ready = 1'b0;
        par_a = 8'hC3;
        fall0 = plfall_a;
        start_a = 1'b1;
        auto_a  = 1'b1;
        tick();
        start_a = 1'b0;
        auto_a  = 1'b0;
        repeat (25) tick();
        check("a_dual_plfalls", plfall_a - fall0, 32'd1);
        check("a_dual_data", {24'd0, bus_a.Data}, 32'hC3);
        bus_a.Ready = 1'b1;
        tick();
        check("a_dual_accept", {31'd0, bus_a.Valid}, 32'd0);

        // Auto mode: back-to-back words 8'h00 then 8'hFF
        par_a = 8'h00;
        auto_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (16) tick();
        tick();
        check("a_auto1_valid", {31'd0, bus_a.Valid}, 32'd1);
        check("a_auto1_data", {24'd0, bus_a.Data}, 32'h00);
        par_a = 8'hFF;
        tick();
        check("a_auto_reload", {29'd0, pl_a, bus_a.Valid, busy_a}, 32'b001);
        repeat (16) tick();
        tick();
        check("a_auto2_valid", {31'd0, bus_a.Valid}, 32'd1);
        check("a_auto2_data", {24'd0, bus_a.Data}, 32'hFF);
        auto_a = 1'b0;
        tick();
        check("a_auto_stop", {29'd0, pl_a, bus_a.Valid, busy_a}, 32'b100);

        // Reset during the 5th SHIFT_HI cycle
        bus_a.Ready = 1'b0;
        par_a = 8'hFF;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (10) tick();
        check("a_mid_srclk", {31'd0, srclk_a}, 32'd1);
        rst_a = 1'b0;
        tick();
        check("a_mid_rst_ctl", {28'd0, pl_a, srclk_a, bus_a.Valid, busy_a}, 32'b1000);
        check("a_mid_rst_data", {24'd0, bus_a.Data}, 32'h0);
        rst_a = 1'b1;
        par_a = 8'h3C;
        bus_a.Ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (16) tick();
        check("a_post_pre", {31'd0, bus_a.Valid}, 32'd0);
        tick();
        check("a_post_valid", {31'd0, bus_a.Valid}, 32'd1);
        check("a_post_data", {24'd0, bus_a.Data}, 32'h3C);
        tick();
        check("a_post_drop", {31'd0, bus_a.Valid}, 32'd0);

        // Two-device chain, CLK_DIV=3: near 8'hA5, far 8'h3C
        par_b = {8'hA5, 8'h3C};
        rise0 = rise_b;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int k = 0; k <= 97; k++) begin
            if (k > 0) tick();
            pl_log[k]    = pl_b;
            srclk_log[k] = srclk_b;
            busy_log[k]  = busy_b;
            valid_log[k] = bus_b.Valid;
        end
        mm_pl = 0;
        mm_sr = 0;
        mm_busy = 0;
        for (int k = 0; k <= 97; k++) begin
            if (pl_log[k] !== (k > 2)) mm_pl++;
            if (srclk_log[k] !== ((k >= 6) && (k <= 95) && (((k - 6) % 6) < 3))) mm_sr++;
            if (busy_log[k] !== (k <= 95)) mm_busy++;
        end
        check("b_pl_timing", mm_pl, 32'd0);
        check("b_srclk_timing", mm_sr, 32'd0);
        check("b_busy_timing", mm_busy, 32'd0);
        check("b_lat96_valid", {31'd0, valid_log[96]}, 32'd0);
        check("b_lat97_valid", {31'd0, valid_log[97]}, 32'd1);
        check("b_data", {16'd0, bus_b.Data}, 32'hA53C);
        check("b_rises", rise_b - rise0, 32'd15);
        bus_b.Ready = 1'b1;
        tick();
        check("b_accept", {30'd0, bus_b.Valid, busy_b}, 32'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
